ag32gbd_buffer_sched: RTL
=========================

AG32GBD_BUFFER_SCHED -- requirements
Module: ag32gbd_buffer_sched

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: sys_clock (in, 1, rising-edge clock for all state) and resetn (in, 1, synchronous active-low reset sampled on sys_clock).
REQ-002 SHALL have the pixel stream inputs: PixelValid (in, 1, byte offered); PixelData (in, 8, pixel byte); FrameStart (in, 1, one-cycle pulse marking a new frame).
REQ-003 SHALL have PixelReady (out, 1): the skid register can accept a byte.
REQ-004 SHALL have the host register-write inputs: HostRegWrite (in, 1, level request, held until acknowledged); HostRegAddr (in, 10, target address); HostRegData (in, 8, write data).
REQ-005 SHALL have HostRegAck (out, 1): one-cycle pulse when the host write completes.
REQ-006 SHALL have the controller-side outputs: RequestWriteReg (out, 1); RegWriteAddr (out, 10); RegWriteData (out, 8); RequestWriteBuffer (out, 1); BufferWriteOffset (out, 10); BufferWriteData (out, 8); FlipBuffer (out, 1, level, toggled per frame).
REQ-007 SHALL have the status outputs: FrameDone (out, 1, one-cycle pulse); FrameCount (out, 8, completed frames); Overflow (out, 1, sticky dropped-byte flag).

Function
REQ-008 SHALL hold at most one pixel byte in the skid register; PixelReady = skid empty; byte captured when PixelValid && PixelReady.
REQ-009 SHALL run FSM states IDLE, REG_REQ, REG_HOLD, PIX_REQ, PIX_HOLD, FLIP_WAIT.
REQ-010 IDLE: pending HostRegWrite -> REG_REQ; else skid full -> PIX_REQ; else stay. Host write wins when both are pending.
REQ-011 REG_REQ (1 cycle): RequestWriteReg=1; RegWriteAddr/RegWriteData loaded from host inputs -> REG_HOLD.
REQ-012 REG_HOLD (3 cycles): RequestWriteReg=0; addr/data held stable; on the last cycle HostRegAck=1 -> IDLE.
REQ-013 PIX_REQ (1 cycle): RequestWriteBuffer=1; BufferWriteData=skid byte; BufferWriteOffset={2'b00, offset[7:0]}; skid freed -> PIX_HOLD.
REQ-014 PIX_HOLD (3 cycles): RequestWriteBuffer=0; data/offset held stable; on exit offset increments mod 256. If the written offset was 255 -> FLIP_WAIT, else -> IDLE.
REQ-015 Request timing: each request is high exactly 1 cycle, low at least 3 cycles; RequestWriteReg and RequestWriteBuffer are never both high, and their hold windows never overlap.
REQ-016 Entry to FLIP_WAIT: FlipBuffer toggles; FrameDone=1 for 1 cycle; FrameCount increments, wrapping 255->0.
REQ-017 FLIP_WAIT lasts 12 cycles, with no requests issued; the skid may still fill -> IDLE.
REQ-018 FrameStart: offset resets to 0 (a partial frame is discarded with no flip or FrameDone). If it arrives during a HOLD state, the write in flight completes and its offset increment is suppressed.
REQ-019 Throughput: at most one pixel byte per 4 cycles outside FLIP_WAIT.

Reset
REQ-020 On resetn=0 at a clock edge, SHALL set: FSM=IDLE, skid empty, offset=0, FrameCount=0, FlipBuffer=0, Overflow=0. All request, ack and pulse outputs=0. Addr/data/offset outputs=0. PixelReady=1 from the first cycle after reset.
REQ-021 Reset mid-transaction SHALL abandon the transaction without an ack. The host re-presents the request after reset.

Configuration
REQ-022 With macro AG32GBD_SCHED_OVERFLOW_EN defined: PixelValid while the skid is full drops the byte and sets Overflow. Overflow is cleared only by reset or FrameStart.
REQ-023 Without AG32GBD_SCHED_OVERFLOW_EN: Overflow is constant 0, and PixelValid while PixelReady=0 is ignored (the upstream holds the byte).

Verification
REQ-024 Single host write, addr 0x3F0, data 0xA5 -> RequestWriteReg high 1 cycle, addr/data stable 4 cycles, HostRegAck 4 cycles after leaving IDLE.
REQ-025 256 bytes 0x00..0xFF at one per 4 cycles -> offsets 0..255 in order, then FlipBuffer 0->1, FrameDone pulse, FrameCount=1, 12 idle cycles before the next request.
REQ-026 HostRegWrite and pixel pending in the same IDLE cycle -> register write issued first, pixel write follows with no overlap; request high cycles always at least 4 apart.
REQ-027 FrameStart after 100 bytes -> next byte written at offset 0, FlipBuffer unchanged, no FrameDone.
REQ-028 With AG32GBD_SCHED_OVERFLOW_EN, PixelValid every cycle -> bytes dropped, Overflow=1 until FrameStart. Without the macro -> no drops, Overflow=0.

Source files
------------

// File: rtl/ag32gbd_buffer_sched.sv
// Pixel/host write scheduler: one-byte skid, request/hold handshakes, frame flip.
// Optional AG32GBD_SCHED_OVERFLOW_EN adds a sticky dropped-byte flag.
module ag32gbd_buffer_sched (
    input  logic       sys_clock,
    input  logic       resetn,
    input  logic       PixelValid,
    input  logic [7:0] PixelData,
    input  logic       FrameStart,
    output logic       PixelReady,
    input  logic       HostRegWrite,
    input  logic [9:0] HostRegAddr,
    input  logic [7:0] HostRegData,
    output logic       HostRegAck,
    output logic       RequestWriteReg,
    output logic [9:0] RegWriteAddr,
    output logic [7:0] RegWriteData,
    output logic       RequestWriteBuffer,
    output logic [9:0] BufferWriteOffset,
    output logic [7:0] BufferWriteData,
    output logic       FlipBuffer,
    output logic       FrameDone,
    output logic [7:0] FrameCount,
    output logic       Overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG_REQ,
        S_REG_HOLD,
        S_PIX_REQ,
        S_PIX_HOLD,
        S_FLIP_WAIT
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_skid_full;
    logic [7:0] r_skid_data;
    logic [7:0] r_offset;
    logic       r_fs_seen;
    logic       r_req_reg;
    logic [9:0] r_reg_addr;
    logic [7:0] r_reg_data;
    logic       r_ack;
    logic       r_req_buf;
    logic [7:0] r_buf_off;
    logic [7:0] r_buf_data;
    logic       r_flip;
    logic       r_done;
    logic [7:0] r_fcount;

    logic       w_accept;
    logic [7:0] w_off_now;

    assign w_accept  = PixelValid && !r_skid_full;
    // A FrameStart in the same cycle as a pixel launch already counts.
    assign w_off_now = FrameStart ? 8'd0 : r_offset;

    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            r_skid_full <= 1'b0;
            r_skid_data <= 8'd0;
        end else if (r_state == S_PIX_REQ) begin
            r_skid_full <= 1'b0;
        end else if (w_accept) begin
            r_skid_full <= 1'b1;
            r_skid_data <= PixelData;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_offset   <= 8'd0;
            r_fs_seen  <= 1'b0;
            r_req_reg  <= 1'b0;
            r_reg_addr <= 10'd0;
            r_reg_data <= 8'd0;
            r_ack      <= 1'b0;
            r_req_buf  <= 1'b0;
            r_buf_off  <= 8'd0;
            r_buf_data <= 8'd0;
            r_flip     <= 1'b0;
            r_done     <= 1'b0;
            r_fcount   <= 8'd0;
        end else begin
            r_req_reg <= 1'b0;
            r_req_buf <= 1'b0;
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            if (FrameStart) begin
                r_offset <= 8'd0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (HostRegWrite) begin
                        r_state    <= S_REG_REQ;
                        r_req_reg  <= 1'b1;
                        r_reg_addr <= HostRegAddr;
                        r_reg_data <= HostRegData;
                    end else if (r_skid_full) begin
                        r_state    <= S_PIX_REQ;
                        r_req_buf  <= 1'b1;
                        r_buf_off  <= w_off_now;
                        r_buf_data <= r_skid_data;
                        r_fs_seen  <= 1'b0;
                    end
                end
                S_REG_REQ: begin
                    r_state <= S_REG_HOLD;
                    r_cnt   <= 4'd0;
                end
                S_REG_HOLD: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_ack <= 1'b1;
                    end
                    if (r_cnt == 4'd2) begin
                        r_state <= S_IDLE;
                    end
                end
                S_PIX_REQ: begin
                    r_state <= S_PIX_HOLD;
                    r_cnt   <= 4'd0;
                    if (FrameStart) begin
                        r_fs_seen <= 1'b1;
                    end
                end
                S_PIX_HOLD: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (FrameStart) begin
                        r_fs_seen <= 1'b1;
                    end
                    // A frame restart during the write cancels both the
                    // offset advance and any frame completion.
                    if (r_cnt == 4'd2) begin
                        if (r_fs_seen || FrameStart) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_offset <= r_buf_off + 8'd1;
                            if (r_buf_off == 8'hFF) begin
                                r_state  <= S_FLIP_WAIT;
                                r_cnt    <= 4'd0;
                                r_flip   <= !r_flip;
                                r_done   <= 1'b1;
                                r_fcount <= r_fcount + 8'd1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                S_FLIP_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd11) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AG32GBD_SCHED_OVERFLOW_EN
    logic r_ovf;

    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            r_ovf <= 1'b0;
        end else if (FrameStart) begin
            r_ovf <= 1'b0;
        end else if (PixelValid && r_skid_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign Overflow = r_ovf;
`else
    assign Overflow = 1'b0;
`endif

    assign PixelReady         = !r_skid_full;
    assign HostRegAck         = r_ack;
    assign RequestWriteReg    = r_req_reg;
    assign RegWriteAddr       = r_reg_addr;
    assign RegWriteData       = r_reg_data;
    assign RequestWriteBuffer = r_req_buf;
    assign BufferWriteOffset  = {2'b00, r_buf_off};
    assign BufferWriteData    = r_buf_data;
    assign FlipBuffer         = r_flip;
    assign FrameDone          = r_done;
    assign FrameCount         = r_fcount;

endmodule
